// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing type, 640x480@60 default timing and total-length helper.
//   No ports; imported by vga_delay_line and vga_scan_ctrl.
package vga_pkg;
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_timing_t;
  localparam vga_timing_t VGA_H_640 = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_timing_t VGA_V_480 = '{active: 480, fp: 10, sync: 2, bp: 33};
  function automatic int vga_total(vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit shift register of depth D with synchronous active-low clear.
//   clk  : clock
//   clrn : synchronous active-low clear of every stage
//   d    : input word
//   q    : d delayed by D cycles (D=0 is a plain wire)
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  generate
    if (D == 0) begin : g_pass
      assign q = d;
    end else begin : g_sr
      logic [W-1:0] sr [D];
      always_ff @(posedge clk) begin
        if (!clrn) sr <= '{default: '0};
        else begin
          sr[0] <= d;
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign q = sr[D-1];
    end
  endgenerate
endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: parametrised VGA scan controller with pixel-source latency alignment.
//   clk         : pixel clock          clrn      : synchronous active-low reset
//   d_in        : pixel {b,g,r}, valid PIX_LAT cycles after its address
//   row_addr    : requested row        col_addr  : requested column
//   rdn         : active-low read strobe (low inside the active area)
//   r, g, b     : output colour        hs, vs    : sync outputs (HS_POL/VS_POL active)
//   frame_start : pulse at output pixel (0,0)
//   line_start  : pulse at output column 0 of each active line
//   Macro VGA_TEST_PATTERN_EN adds pattern_sel, which swaps d_in for 8 colour bars.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_640.active,
  parameter int   H_FP     = VGA_H_640.fp,
  parameter int   H_SYNC   = VGA_H_640.sync,
  parameter int   H_BP     = VGA_H_640.bp,
  parameter int   V_ACTIVE = VGA_V_480.active,
  parameter int   V_FP     = VGA_V_480.fp,
  parameter int   V_SYNC   = VGA_V_480.sync,
  parameter int   V_BP     = VGA_V_480.bp,
  parameter int   COLOR_W  = 4,
  parameter int   PIX_LAT  = 1,
  parameter int   SCALE    = 1,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 clrn,
  input  logic [3*COLOR_W-1:0]                 d_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                                 pattern_sel,
`endif
  output logic [$clog2(V_ACTIVE/SCALE)-1:0]    row_addr,
  output logic [$clog2(H_ACTIVE/SCALE)-1:0]    col_addr,
  output logic                                 rdn,
  output logic [COLOR_W-1:0]                   r,
  output logic [COLOR_W-1:0]                   g,
  output logic [COLOR_W-1:0]                   b,
  output logic                                 hs,
  output logic                                 vs,
  output logic                                 frame_start,
  output logic                                 line_start
);
  localparam int H_TOTAL = vga_total('{H_ACTIVE, H_FP, H_SYNC, H_BP});
  localparam int V_TOTAL = vga_total('{V_ACTIVE, V_FP, V_SYNC, V_BP});
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int RW = $clog2(V_ACTIVE / SCALE);
  localparam int CW = $clog2(H_ACTIVE / SCALE);
  localparam int SH = $clog2(SCALE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_A    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_ON  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_A    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ON  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_TEST_PATTERN_EN
  localparam int DW = 5 + HW;
`else
  localparam int DW = 5;
`endif
  generate
    if (!(SCALE == 1 || SCALE == 2 || SCALE == 4) || PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_cfg
      $error("vga_scan_ctrl: SCALE must be 1, 2 or 4 and PIX_LAT must be 0..7");
    end
  endgenerate
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, act;
  logic [DW-1:0] s0_c, s0, dl;
  assign h_last = h_cnt == H_LAST;
  assign v_last = v_cnt == V_LAST;
  assign act    = (h_cnt < H_A) && (v_cnt < V_A);
  // flag word: {[column], act, hs_raw, vs_raw, frame flag, line flag}
`ifdef VGA_TEST_PATTERN_EN
  assign s0_c = {h_cnt, act, (h_cnt >= HS_ON) && (h_cnt < HS_OFF), (v_cnt >= VS_ON) && (v_cnt < VS_OFF),
                 (h_cnt == '0) && (v_cnt == '0), (h_cnt == '0) && (v_cnt < V_A)};
`else
  assign s0_c = {act, (h_cnt >= HS_ON) && (h_cnt < HS_OFF), (v_cnt >= VS_ON) && (v_cnt < VS_OFF),
                 (h_cnt == '0) && (v_cnt == '0), (h_cnt == '0) && (v_cnt < V_A)};
`endif
  always_ff @(posedge clk) begin
    if (!clrn) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      s0       <= '0;
      row_addr <= '0;
      col_addr <= '0;
      rdn      <= 1'b1;
    end else begin
      h_cnt    <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      s0       <= s0_c;
      row_addr <= act ? RW'(v_cnt >> SH) : '0;
      col_addr <= act ? CW'(h_cnt >> SH) : '0;
      rdn      <= ~act;
    end
  end
  // flags travel alongside the pixel source so they meet d_in in the output register
  vga_delay_line #(.W(DW), .D(PIX_LAT)) u_dly (
    .clk  (clk),
    .clrn (clrn),
    .d    (s0),
    .q    (dl)
  );
  logic [3*COLOR_W-1:0] pix;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  always_comb begin
    bar = 3'((int'(dl[DW-1:5]) * 8) / H_ACTIVE);
    pix = !dl[4] ? '0 : pattern_sel ? {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}} : d_in;
  end
`else
  assign pix = dl[4] ? d_in : '0;
`endif
  always_ff @(posedge clk) begin
    if (!clrn) begin
      {b, g, r}   <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      {b, g, r}   <= pix;
      hs          <= dl[3] ? HS_POL : ~HS_POL;
      vs          <= dl[2] ? VS_POL : ~VS_POL;
      frame_start <= dl[1];
      line_start  <= dl[0];
    end
  end
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: directed checks of a default 640x480 instance and a tiny scaled instance.
module tb_vga_scan_ctrl;
`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic clrn = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  logic [11:0] a_din = 12'h00F;
  logic [8:0]  a_row;
  logic [9:0]  a_col;
  logic [3:0]  a_r, a_g, a_b;
  logic        a_rdn, a_hs, a_vs, a_fs, a_ls;
  vga_scan_ctrl u_a (
    .clk(clk), .clrn(clrn), .d_in(a_din),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .row_addr(a_row), .col_addr(a_col), .rdn(a_rdn), .r(a_r), .g(a_g), .b(a_b),
    .hs(a_hs), .vs(a_vs), .frame_start(a_fs), .line_start(a_ls)
  );
  logic [11:0] b_din;
  logic [0:0]  b_row;
  logic [1:0]  b_col;
  logic [3:0]  b_r, b_g, b_b;
  logic        b_rdn, b_hs, b_vs, b_fs, b_ls;
  vga_scan_ctrl #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_LAT(3), .SCALE(2), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_b (
    .clk(clk), .clrn(clrn), .d_in(b_din),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(1'b1),
`endif
    .row_addr(b_row), .col_addr(b_col), .rdn(b_rdn), .r(b_r), .g(b_g), .b(b_b),
    .hs(b_hs), .vs(b_vs), .frame_start(b_fs), .line_start(b_ls)
  );
  // three-cycle pixel source echoing the requested column
  logic [1:0] pipe [3];
  always @(posedge clk) begin
    pipe[0] <= b_col;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign b_din = {10'b0, pipe[2]};
  task automatic chk(input string tag, input int n, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, o, e);
    end
  endtask
  task automatic chk_reset();
    chk("a_rst_rdn", -1, a_rdn, 1); chk("a_rst_col", -1, a_col, 0); chk("a_rst_row", -1, a_row, 0);
    chk("a_rst_hs", -1, a_hs, 1); chk("a_rst_vs", -1, a_vs, 1); chk("a_rst_rgb", -1, {a_r, a_g, a_b}, 0);
    chk("a_rst_fs", -1, a_fs, 0); chk("a_rst_ls", -1, a_ls, 0);
    chk("b_rst_rdn", -1, b_rdn, 1); chk("b_rst_col", -1, b_col, 0); chk("b_rst_row", -1, b_row, 0);
    chk("b_rst_hs", -1, b_hs, 0); chk("b_rst_vs", -1, b_vs, 0); chk("b_rst_rgb", -1, {b_r, b_g, b_b}, 0);
    chk("b_rst_fs", -1, b_fs, 0); chk("b_rst_ls", -1, b_ls, 0);
  endtask
  // default instance: n counts cycles since release, outputs trail addresses by 2
  task automatic run_a(input int cycles);
    int hs_low = 0;
    for (int n = 0; n < cycles; n++) begin
      int h, v, m, hm, vm;
      bit act, ok, am;
      @(negedge clk);
      h = n % 800; v = n / 800; act = h < 640 && v < 480;
      chk("a_rdn", n, a_rdn, !act);
      chk("a_col", n, a_col, act ? h : 0);
      chk("a_row", n, a_row, act ? v : 0);
      m = n - 2; ok = m >= 0;
      hm = ok ? m % 800 : 0; vm = ok ? m / 800 : 0; am = ok && hm < 640 && vm < 480;
      chk("a_hs", n, a_hs, !(ok && hm >= 656 && hm < 752));
      chk("a_vs", n, a_vs, 1);
      chk("a_r", n, a_r, am ? 15 : 0);
      chk("a_gb", n, {a_g, a_b}, 0);
      chk("a_fs", n, a_fs, ok && m == 0);
      chk("a_ls", n, a_ls, ok && hm == 0 && vm < 480);
      if (ok && m < 800 && !a_hs) hs_low++;
    end
    chk("a_hs_low_cycles", 0, hs_low, 96);
  endtask
  // tiny instance: 12x7 frame, outputs trail addresses by PIX_LAT+1 = 4
  task automatic run_b(input int cycles);
    int fs_cnt = 0;
    int last_fs = -1;
    for (int n = 0; n < cycles; n++) begin
      int h, v, m, hm, vm;
      bit act, ok, am;
      @(negedge clk);
      h = n % 12; v = (n / 12) % 7; act = h < 8 && v < 4;
      chk("b_rdn", n, b_rdn, !act);
      chk("b_col", n, b_col, act ? h / 2 : 0);
      chk("b_row", n, b_row, act ? v / 2 : 0);
      m = n - 4; ok = m >= 0;
      hm = ok ? m % 12 : 0; vm = ok ? (m / 12) % 7 : 0; am = ok && hm < 8 && vm < 4;
      chk("b_hs", n, b_hs, ok && hm >= 9 && hm < 11);
      chk("b_vs", n, b_vs, ok && vm == 5);
      chk("b_r", n, b_r, !am ? 0 : PAT ? (hm & 1) * 15 : hm / 2);
      chk("b_g", n, b_g, (am && PAT) ? ((hm >> 1) & 1) * 15 : 0);
      chk("b_b", n, b_b, (am && PAT) ? ((hm >> 2) & 1) * 15 : 0);
      chk("b_fs", n, b_fs, ok && hm == 0 && vm == 0);
      chk("b_ls", n, b_ls, ok && hm == 0 && vm < 4);
      if (b_fs) begin
        if (last_fs >= 0) chk("b_frame_period", n, n - last_fs, 84);
        last_fs = n;
        fs_cnt++;
      end
    end
    chk("b_frame_count", cycles, fs_cnt, (cycles - 5) / 84 + 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    clrn = 1'b1;
    run_a(1700);
    clrn = 1'b0;
    @(negedge clk);
    chk_reset();
    clrn = 1'b1;
    run_b(125);
    clrn = 1'b0;
    @(negedge clk);
    chk_reset();
    clrn = 1'b1;
    run_b(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Parametrised VGA scan controller; successor to the fixed 640x480 sync block.
- Generates H/V counters, sync pulses and pixel read addresses, with configurable timing, colour depth, sync polarity, pixel-source latency and integer pixel scaling.
- Re-aligns returned pixel data with delayed sync/blank so the external pixel source (lane renderer, framebuffer) may be pipelined.
- Sits between the game renderer and the board VGA pins.

Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BP, 48: horizontal back porch.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BP, 33: vertical back porch.
- COLOR_W, 4: bits per colour channel.
- PIX_LAT, 1: cycles from address out to valid d_in; range 0..7.
- SCALE, 1: address divisor, power of two (1, 2 or 4).
- HS_POL, 0: active level of hs.
- VS_POL, 0: active level of vs.

Ports:
- clk  in  1  pixel clock, one pixel per cycle.
- clrn  in  1  synchronous active-low reset.
- d_in  in  3*COLOR_W  pixel data {b,g,r}, valid PIX_LAT cycles after its address.
- row_addr  out  clog2(V_ACTIVE/SCALE)  pixel row being requested.
- col_addr  out  clog2(H_ACTIVE/SCALE)  pixel column being requested.
- rdn  out  1  active-low read strobe, low while the address is in the active area.
- r, g, b  out  COLOR_W each  output colour, zero in blanking.
- hs  out  1  horizontal sync.
- vs  out  1  vertical sync.
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0).
- line_start  out  1  one-cycle pulse aligned with output column 0 of each active line.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (clrn, sampled on the rising edge of clk).
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps, and wraps to 0 when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 coincide.
- Stage 0 (counters, registered):
  - act = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - col_addr = h_cnt>>log2(SCALE) and row_addr = v_cnt>>log2(SCALE) when act, else 0.
  - rdn = ~act.
- Sync regions:
  - hs_raw is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Alignment pipeline:
  - act, hs_raw, vs_raw and the start flags are delayed PIX_LAT cycles, then registered once more together with d_in.
  - Total latency from address to r/g/b/hs/vs is PIX_LAT+1 cycles.
  - The relative sync-to-pixel timing equals the counter timing exactly.
- Output stage: r/g/b = d_in fields when the delayed act is 1, else 0.
- Pulses:
  - frame_start = delayed (h_cnt==0 && v_cnt==0).
  - line_start = delayed (h_cnt==0 && v_cnt<V_ACTIVE).
- Reset values (all registered):
  - h_cnt=0, v_cnt=0, all delay stages cleared.
  - r=g=b=0, hs=~HS_POL, vs=~VS_POL, rdn=1, frame_start=0, line_start=0, row_addr=0, col_addr=0.
- Reset mid-frame: counters restart at (0,0) on the next cycle. The first frame_start after reset occurs PIX_LAT+1 cycles after clrn deasserts. No partial sync pulse is extended.
- Out-of-range parameters: SCALE not a power of two, or PIX_LAT>7, fail elaboration via a generate-time check.

Optional Feature:
- VGA_TEST_PATTERN_EN defined:
  - Adds input pattern_sel (1 bit).
  - When pattern_sel=1, d_in is ignored and the output shows 8 vertical colour bars.
  - Bar index = output column*8/H_ACTIVE; colour bits {b,g,r} = index bits, each channel all-ones or zero.
  - Pattern column is taken from the delayed counter, so alignment is identical.
- Undefined: port absent; d_in is always used.

Decomposition:
- Package vga_pkg holds:
  - default 640x480@60 timing constants;
  - a timing struct typedef (active/fp/sync/bp);
  - function vga_total().
- Natural sub-module: vga_delay_line, a parametrised-width, parametrised-depth shift register with synchronous active-low clear. It is used for the PIX_LAT alignment of act/hs/vs/start flags.

Test Plan:
- Defaults, free-run two frames -> frame_start period 420000 cycles; hs low for 96 cycles every 800; vs low for 2 lines (1600 cycles) starting at line 490.
- Defaults, d_in = {4'h0,4'h0,4'hF} constant -> r=F,g=0,b=0 in the active area, all zero in blanking; first visible pixel PIX_LAT+1 cycles after rdn falls.
- PIX_LAT=3, d_in = col_addr low 12 bits echoed through a 3-stage model -> each output pixel value equals its own column. No off-by-one at columns 0 and 639.
- SCALE=2 -> col_addr repeats each value twice (0,0,1,1,...,319,319); row_addr changes every 2 lines and reaches max 239.
- Assert clrn=0 for 1 cycle at h_cnt=300, v_cnt=100 -> next cycle counters at 0, hs/vs inactive, rgb=0; frame_start 2 cycles after release (PIX_LAT=1).
- Tiny timing (H 8/1/2/1, V 4/1/1/1, HS_POL=1) plus VGA_TEST_PATTERN_EN with pattern_sel=1 -> hs high for 2 cycles per 12-cycle line; bar index increments every active column.
